// File: rtl/stopwatch_pkg.sv
`default_nettype none
// ============================================================================
// Module   : stopwatch_pkg
// Brief    : State encoding and default timing constants for the stopwatch
//            controller.
// Revision : 1.0 - initial release
// ============================================================================
package stopwatch_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        RUN   = 2'b01,
        PAUSE = 2'b10,
        LAP   = 2'b11
    } state_t;

    localparam int c_clk_hz          = 100_000_000;
    localparam int c_tick_hz         = 10;
    localparam int c_debounce_cycles = 1_000_000;

    // RUN and LAP are the states in which time advances.
    function automatic logic is_counting(input state_t s);
        return (s == RUN) || (s == LAP);
    endfunction

endpackage
`default_nettype wire

// File: rtl/btn_debounce.sv
`default_nettype none
// ============================================================================
// Module   : btn_debounce
// Brief    : 2-FF synchronizer, stability-count debouncer and rising-edge
//            press pulse for one raw push button.
// Revision : 1.0 - initial release
// ============================================================================
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = stopwatch_pkg::c_debounce_cycles
) (
    input  logic clk,
    input  logic rst,
    input  logic i_btn,
    output logic o_press
);

    localparam int                 c_cnt_w    = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(DEBOUNCE_CYCLES - 1);
    localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);

    logic               r_sync1;
    logic               r_sync2;
    logic               r_level;
    logic               r_armed;
    logic               r_press;
    logic [c_cnt_w-1:0] r_cnt;

    // r_armed stays low until the button is seen debounced-low, so a button
    // held through reset cannot fire until it is released and pressed again.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_level <= 1'b0;
            r_armed <= 1'b0;
            r_press <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_sync1 <= i_btn;
            r_sync2 <= r_sync1;
            r_press <= 1'b0;
            if (r_sync2 != r_level) begin
                if (r_cnt == c_cnt_last) begin
                    r_level <= r_sync2;
                    r_cnt   <= '0;
                    r_press <= r_sync2 & r_armed;
                end else begin
                    r_cnt <= r_cnt + c_cnt_one;
                end
            end else if (!r_armed && !r_sync2) begin
                if (r_cnt == c_cnt_last) begin
                    r_armed <= 1'b1;
                    r_cnt   <= '0;
                end else begin
                    r_cnt <= r_cnt + c_cnt_one;
                end
            end else begin
                r_cnt <= '0;
            end
        end
    end

    assign o_press = r_press;

endmodule
`default_nettype wire

// File: rtl/stopwatch_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : stopwatch_ctrl
// Brief    : Start/stop/lap stopwatch control FSM with tick prescaler and
//            debounced buttons. Define STOPWATCH_AUTO_STOP_EN to pause
//            automatically when the datapath reports its maximum count.
// Revision : 1.0 - initial release
// ============================================================================
module stopwatch_ctrl #(
    parameter int CLK_HZ          = stopwatch_pkg::c_clk_hz,
    parameter int TICK_HZ         = stopwatch_pkg::c_tick_hz,
    parameter int DEBOUNCE_CYCLES = stopwatch_pkg::c_debounce_cycles
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       btn_start,
    input  logic       btn_lap,
    input  logic       max_reached,
    output logic       tick_en,
    output logic       cnt_clear,
    output logic       disp_hold,
    output logic       led,
    output logic [1:0] state
);

    import stopwatch_pkg::*;

    localparam int                   c_div        = CLK_HZ / TICK_HZ;
    localparam int                   c_presc_w    = $clog2(c_div);
    localparam logic [c_presc_w-1:0] c_presc_last = c_presc_w'(c_div - 1);
    localparam logic [c_presc_w-1:0] c_presc_one  = c_presc_w'(1);

    logic                 w_start;
    logic                 w_lap;
    logic                 w_clear;
    logic                 w_active;
    logic                 w_next_active;
    logic                 w_wrap;
    state_t               r_state;
    state_t               w_next;
    logic [c_presc_w-1:0] r_presc;
    logic                 r_tick;
    logic                 r_clear;
    logic                 r_hold;
    logic                 r_led;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_dbc_start (
        .clk     (clock),
        .rst     (reset),
        .i_btn   (btn_start),
        .o_press (w_start)
    );

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_dbc_lap (
        .clk     (clock),
        .rst     (reset),
        .i_btn   (btn_lap),
        .o_press (w_lap)
    );

    // Start is tested first in every state, so a simultaneous lap is dropped.
    always_comb begin
        w_next  = r_state;
        w_clear = 1'b0;
        case (r_state)
            IDLE:    if (w_start) w_next = RUN;
            RUN:     if (w_start) w_next = PAUSE; else if (w_lap) w_next = LAP;
            LAP:     if (w_start) w_next = PAUSE; else if (w_lap) w_next = RUN;
            PAUSE: begin
                if (w_start) begin
                    w_next = RUN;
                end else if (w_lap) begin
                    w_next  = IDLE;
                    w_clear = 1'b1;
                end
            end
            default: w_next = IDLE;
        endcase
`ifdef STOPWATCH_AUTO_STOP_EN
        if (is_counting(r_state) && max_reached) begin
            w_next  = PAUSE;
            w_clear = 1'b0;
        end
`endif
    end

`ifndef STOPWATCH_AUTO_STOP_EN
    logic w_unused_max;
    assign w_unused_max = max_reached;
`endif

    assign w_active      = is_counting(r_state);
    assign w_next_active = is_counting(w_next);
    assign w_wrap        = (r_presc == c_presc_last);

    // A wrap coinciding with leaving RUN/LAP emits no tick, keeping tick_en
    // low whenever the registered state is IDLE or PAUSE.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= IDLE;
            r_presc <= '0;
            r_tick  <= 1'b0;
            r_clear <= 1'b0;
            r_hold  <= 1'b0;
            r_led   <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_next == IDLE) begin
                r_presc <= '0;
            end else if (w_active) begin
                r_presc <= w_wrap ? '0 : r_presc + c_presc_one;
            end
            r_tick  <= w_active & w_next_active & w_wrap;
            r_clear <= w_clear;
            r_hold  <= (w_next == LAP);
            r_led   <= w_next_active;
        end
    end

    assign state     = r_state;
    assign tick_en   = r_tick;
    assign cnt_clear = r_clear;
    assign disp_hold = r_hold;
    assign led       = r_led;

endmodule
`default_nettype wire

// File: tb/tb_stopwatch_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_stopwatch_ctrl
// Brief    : Directed self-checking bench for stopwatch_ctrl
//            (CLK_HZ=100, TICK_HZ=10, DEBOUNCE_CYCLES=4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_stopwatch_ctrl;

    localparam logic [1:0] c_idle  = 2'b00;
    localparam logic [1:0] c_run   = 2'b01;
    localparam logic [1:0] c_pause = 2'b10;
    localparam logic [1:0] c_lap   = 2'b11;

    logic       clock;
    logic       reset;
    logic       btn_start;
    logic       btn_lap;
    logic       max_reached;
    logic       tick_en;
    logic       cnt_clear;
    logic       disp_hold;
    logic       led;
    logic [1:0] state;

    int n_checks = 0;
    int n_errors = 0;

    stopwatch_ctrl #(
        .CLK_HZ          (100),
        .TICK_HZ         (10),
        .DEBOUNCE_CYCLES (4)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .btn_start   (btn_start),
        .btn_lap     (btn_lap),
        .max_reached (max_reached),
        .tick_en     (tick_en),
        .cnt_clear   (cnt_clear),
        .disp_hold   (disp_hold),
        .led         (led),
        .state       (state)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clock);
    endtask

    // Hold for 6 cycles; the new state is visible 7 negedges after the raise.
    task automatic press(input logic s, input logic l);
        if (s) btn_start = 1'b1;
        if (l) btn_lap = 1'b1;
        step(6);
        btn_start = 1'b0;
        btn_lap   = 1'b0;
        step(1);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_state"}, state, c_idle);
        chk({tag, "_tick"}, tick_en, 1'b0);
        chk({tag, "_clear"}, cnt_clear, 1'b0);
        chk({tag, "_hold"}, disp_hold, 1'b0);
        chk({tag, "_led"}, led, 1'b0);
    endtask

    initial begin
        reset       = 1'b1;
        btn_start   = 1'b0;
        btn_lap     = 1'b0;
        max_reached = 1'b0;
        step(3);
        chk_all_zero("reset");
        reset = 1'b0;
        step(8);

        // Glitch rejection
        btn_start = 1'b1;
        step(3);
        btn_start = 1'b0;
        step(12);
        chk("glitch_state", state, c_idle);
        chk("glitch_led", led, 1'b0);

        btn_start = 1'b1;
        step(6);
        chk("press_pre_state", state, c_idle);
        btn_start = 1'b0;
        step(1);
        chk("press_state", state, c_run);
        chk("press_led", led, 1'b1);
        chk("press_tick", tick_en, 1'b0);

        // Tick cadence: ticks on every 10th cycle after entering RUN
        for (int i = 1; i <= 100; i++) begin
            step(1);
            chk("cadence_tick", tick_en, (i % 10 == 0));
            chk("cadence_led", led, 1'b1);
        end

        // Pause 7 cycles past the last tick
        press(1'b1, 1'b0);
        chk("pause_state", state, c_pause);
        for (int i = 0; i < 50; i++) begin
            step(1);
            chk("pause_tick", tick_en, 1'b0);
            chk("pause_state_hold", state, c_pause);
        end
        press(1'b1, 1'b0);
        chk("resume_state", state, c_run);
        chk("resume_tick0", tick_en, 1'b0);
        step(1);
        chk("resume_tick1", tick_en, 1'b0);
        step(1);
        chk("resume_tick2", tick_en, 1'b0);
        step(1);
        chk("resume_tick3", tick_en, 1'b1);
        step(1);
        chk("resume_tick4", tick_en, 1'b0);

        // Lap view then clear
        press(1'b0, 1'b1);
        chk("lap_state", state, c_lap);
        chk("lap_hold", disp_hold, 1'b1);
        chk("lap_led", led, 1'b1);
        step(2);
        chk("lap_tick", tick_en, 1'b1);
        step(1);
        press(1'b0, 1'b1);
        chk("unlap_state", state, c_run);
        chk("unlap_hold", disp_hold, 1'b0);
        press(1'b1, 1'b0);
        chk("stop_state", state, c_pause);
        chk("stop_led", led, 1'b0);
        chk("stop_hold", disp_hold, 1'b0);
        btn_lap = 1'b1;
        step(6);
        chk("clear_pre", cnt_clear, 1'b0);
        chk("clear_pre_state", state, c_pause);
        btn_lap = 1'b0;
        step(1);
        chk("clear_pulse", cnt_clear, 1'b1);
        chk("clear_state", state, c_idle);
        step(1);
        chk("clear_after", cnt_clear, 1'b0);

        // Lap ignored in IDLE; prescaler restarts from zero
        step(2);
        press(1'b0, 1'b1);
        chk("idle_lap_state", state, c_idle);
        chk("idle_lap_clear", cnt_clear, 1'b0);
        press(1'b1, 1'b0);
        chk("restart_state", state, c_run);
        step(9);
        chk("restart_tick9", tick_en, 1'b0);
        step(1);
        chk("restart_tick10", tick_en, 1'b1);

        // Simultaneous presses: start wins
        press(1'b1, 1'b1);
        chk("both_state", state, c_pause);
        chk("both_hold", disp_hold, 1'b0);
        step(3);
        press(1'b1, 1'b0);
        chk("run_again", state, c_run);
        max_reached = 1'b1;
        step(1);
`ifdef STOPWATCH_AUTO_STOP_EN
        chk("autostop_state", state, c_pause);
        chk("autostop_tick", tick_en, 1'b0);
        chk("autostop_led", led, 1'b0);
        step(2);
        chk("autostop_tick_later", tick_en, 1'b0);
        max_reached = 1'b0;
        press(1'b1, 1'b0);
        chk("autostop_resume", state, c_run);
`else
        chk("maxign_state", state, c_run);
        chk("maxign_led", led, 1'b1);
        step(2);
        chk("maxign_tick", tick_en, 1'b1);
        max_reached = 1'b0;
`endif

        // Reset mid-LAP with start held through reset
        press(1'b0, 1'b1);
        chk("pre_reset_lap", state, c_lap);
        btn_start = 1'b1;
        step(2);
        reset = 1'b1;
        step(1);
        chk_all_zero("midlap_reset");
        step(1);
        reset = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step(1);
            chk("held_start_state", state, c_idle);
        end
        btn_start = 1'b0;
        step(12);
        chk("released_state", state, c_idle);
        press(1'b1, 1'b0);
        chk("repress_state", state, c_run);
        chk("repress_led", led, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/stopwatch_ctrl.md
STOPWATCH_CTRL -- requirements
Module: stopwatch_ctrl

Interface
REQ-001 The parameters SHALL be as follows (name, default, meaning):
- CLK_HZ, 100_000_000, input clock frequency.
- TICK_HZ, 10, count-enable rate (0.1 s resolution).
- DEBOUNCE_CYCLES, 1_000_000, stable cycles required on a button (10 ms).

REQ-002 The ports SHALL be as follows (name, direction, width, meaning):
- clock, in, 1, single clock domain.
- reset, in, 1, synchronous, active-high.
- btn_start, in, 1, raw asynchronous start/stop button.
- btn_lap, in, 1, raw asynchronous lap/clear button.
- max_reached, in, 1, datapath count at maximum (9:59.9).
- tick_en, out, 1, one-cycle count-enable pulse to datapath.
- cnt_clear, out, 1, one-cycle clear pulse to datapath.
- disp_hold, out, 1, freeze display latch (lap view).
- led, out, 1, high while counting.
- state, out, 2, current FSM state.

REQ-003 The clock and reset SHALL be one clock, with reset synchronous and active-high.

Function
REQ-004 Each button SHALL be 2-FF synchronized and then debounced: the debounced level changes only after the synchronized input has been stable for DEBOUNCE_CYCLES consecutive cycles.

REQ-005 A debounced rising edge SHALL produce a one-cycle press pulse; releases and holds produce no pulse.

REQ-006 The FSM states SHALL be IDLE=00, RUN=01, PAUSE=10, LAP=11.

REQ-007 In IDLE, a start press SHALL go to RUN; a lap press is ignored.

REQ-008 In RUN, a start press SHALL go to PAUSE; a lap press goes to LAP.

REQ-009 In LAP, a lap press SHALL go to RUN; a start press goes to PAUSE.

REQ-010 In PAUSE, a start press SHALL go to RUN; a lap press goes to IDLE with cnt_clear pulsed for exactly one cycle.

REQ-011 When a start press and a lap press occur in the same cycle, the start press SHALL take priority and the lap press is dropped.

REQ-012 All outputs SHALL be registered; a press pulse in cycle N yields the new state and outputs in cycle N+1.

REQ-013 The prescaler SHALL count 0..CLK_HZ/TICK_HZ-1 only in RUN/LAP, hold its value in PAUSE, and be zeroed on entry to IDLE.

REQ-014 tick_en SHALL pulse for one cycle on the prescaler wrap while in RUN or LAP, and never in IDLE/PAUSE.

REQ-015 disp_hold SHALL be 1 exactly while in LAP.

REQ-016 led SHALL be 1 in RUN and LAP, and 0 otherwise.

REQ-017 The width of the prescaler SHALL be $clog2(CLK_HZ/TICK_HZ), and CLK_HZ/TICK_HZ >= 2 is required.

Reset
REQ-018 Reset SHALL force state=IDLE, zero the prescaler, zero the debouncer counters/levels/sync flops, and drive tick_en=0, cnt_clear=0, disp_hold=0 and led=0.

REQ-019 Reset asserted mid-RUN/LAP SHALL override any concurrent press or tick in that cycle.

REQ-020 No press pulse SHALL be generated by a button held high through reset until it is released and re-pressed.

Configuration
REQ-021 With STOPWATCH_AUTO_STOP_EN defined, max_reached=1 in RUN/LAP SHALL force the next state to PAUSE (disp_hold cleared) and suppress tick_en in that cycle; this has priority over presses.

REQ-022 Without STOPWATCH_AUTO_STOP_EN, max_reached SHALL be ignored and ticks continue, letting the datapath wrap.

Structure
REQ-023 The package stopwatch_pkg SHALL hold the state typedef and encodings (IDLE/RUN/PAUSE/LAP) and the default parameter constants.

REQ-024 The block SHALL instantiate one sub-module, btn_debounce (synchronizer, debounce counter, rising-edge pulse), twice.

Verification
Bench parameters: CLK_HZ=100, TICK_HZ=10, DEBOUNCE_CYCLES=4.

REQ-025 Glitch rejection: a btn_start pulse of 3 cycles SHALL produce no state change, while a 6-cycle pulse moves IDLE->RUN 4+2+1 cycles after the rising edge.

REQ-026 Tick cadence: in RUN for 100 cycles, tick_en SHALL pulse exactly 10 times, spaced 10 cycles apart, each 1 cycle wide, with led=1.

REQ-027 Pause accuracy: RUN for 7 cycles past a tick, then PAUSE for 50 cycles, then RUN; the next tick SHALL arrive 3 cycles after re-entering RUN, with no ticks during PAUSE.

REQ-028 Lap then clear: RUN->lap gives disp_hold=1 while ticks continue; lap->RUN gives disp_hold=0; start->PAUSE, then lap->IDLE gives cnt_clear=1 for exactly one cycle and state=00.

REQ-029 Priority and auto-stop: simultaneous start+lap presses in RUN SHALL go to PAUSE; with STOPWATCH_AUTO_STOP_EN, max_reached=1 in RUN SHALL give PAUSE next cycle with no tick_en.

REQ-030 Reset mid-LAP: asserting reset SHALL give state=00 and all outputs 0 on the next edge, and a held btn_start SHALL not restart until released and re-pressed.
